// File: rtl/va_ctrl_pio_pkg.sv
// -----------------------------------------------------------------------------
// va_ctrl_pio_pkg
//
// Shared definitions for the vector-analyzer control PIO.
//
// Contents:
//   - Word offsets inside a channel page (DATA/SET/CLR/PULSE).
//   - Word offsets inside the global page (COMMIT/STATUS).
//   - REGS_PER_PAGE: number of words in every page.
//   - cnt_width(): width of the per-channel pulse counter. It must hold the
//     value PULSE_LEN, so it needs $clog2(PULSE_LEN+1) bits.
//
// Build option: VA_CTRL_PIO_SHADOW_EN (used by va_ctrl_pio and va_ctrl_pio_ch).
// -----------------------------------------------------------------------------
package va_ctrl_pio_pkg;

  // Every page, channel or global, is four words long.
  localparam int REGS_PER_PAGE = 4;

  // Channel page offsets.
  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_SET    = 2'd1;
  localparam logic [1:0] OFS_CLR    = 2'd2;
  localparam logic [1:0] OFS_PULSE  = 2'd3;

  // Global page offsets.
  localparam logic [1:0] OFS_COMMIT = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;

  // Width of the pulse down-counter.
  function automatic int cnt_width(input int pulse_len);
    return $clog2(pulse_len + 1);
  endfunction

endpackage : va_ctrl_pio_pkg

// File: rtl/va_ctrl_pio_ch.sv
// -----------------------------------------------------------------------------
// va_ctrl_pio_ch
//
// One control channel of va_ctrl_pio. It holds:
//   - the committed output register,
//   - the shadow register and pending flag (double-buffered build only),
//   - the pulse bits and their down-counter.
//
// Build option VA_CTRL_PIO_SHADOW_EN:
//   defined   - DATA/SET/CLR writes modify the shadow and set pending.
//               commit_i copies the pre-write shadow into out and clears
//               pending. A write in the same cycle wins, so pending stays 1.
//   undefined - DATA/SET/CLR writes modify out directly.
//               commit_i is ignored. shadow_o mirrors out. pending_o is 0.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   wr_data_i        write strobe for the DATA word (load)
//   wr_set_i         write strobe for the SET word (OR)
//   wr_clr_i         write strobe for the CLR word (AND-NOT)
//   wr_pulse_i       write strobe for the PULSE word (OR + counter reload)
//   wdata_i          write data
//   commit_i         commit this channel in the current cycle
//   shadow_o         value returned by a DATA read
//   out_o            committed output value
//   pending_o        shadow holds uncommitted changes
//   pulse_o          self-clearing pulse bits
// -----------------------------------------------------------------------------
module va_ctrl_pio_ch
  import va_ctrl_pio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PULSE_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_data_i,
  input  logic              wr_set_i,
  input  logic              wr_clr_i,
  input  logic              wr_pulse_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              commit_i,
  output logic [DATA_W-1:0] shadow_o,
  output logic [DATA_W-1:0] out_o,
  output logic              pending_o,
  output logic [DATA_W-1:0] pulse_o
);

  localparam int               CNT_W    = cnt_width(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The top decodes one word per access, so at most one strobe is active.
  function automatic logic [DATA_W-1:0] apply_wr(
    input logic [DATA_W-1:0] cur,
    input logic              set_op,
    input logic              clr_op,
    input logic [DATA_W-1:0] wd
  );
    if (set_op) return cur | wd;
    if (clr_op) return cur & ~wd;
    return wd;
  endfunction

  logic              wr_any;
  logic [DATA_W-1:0] out_q,   out_d;
  logic [DATA_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  assign wr_any = wr_data_i | wr_set_i | wr_clr_i;

`ifdef VA_CTRL_PIO_SHADOW_EN
  // ---------------------------------------------------------------------------
  // Double-buffered path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    out_d     = out_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // The commit reads shadow_q, so it transfers the value from before any
    // write landing on the same edge.
    if (commit_i) begin
      out_d     = shadow_q;
      pending_d = 1'b0;
    end
    // A write after (or together with) a commit leaves the channel pending.
    if (wr_any) begin
      shadow_d  = apply_wr(shadow_q, wr_set_i, wr_clr_i, wdata_i);
      pending_d = 1'b1;
    end
  end

  // NOTE: the shadow is a single flop register, not a RAM, so it takes the
  // asynchronous reset like every other piece of channel state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign shadow_o  = shadow_q;
  assign pending_o = pending_q;
`else
  // ---------------------------------------------------------------------------
  // Direct path: writes act on out, no shadow or pending storage.
  // ---------------------------------------------------------------------------
  logic unused_commit;
  assign unused_commit = commit_i;

  always_comb begin
    out_d = out_q;
    if (wr_any) begin
      out_d = apply_wr(out_q, wr_set_i, wr_clr_i, wdata_i);
    end
  end

  assign shadow_o  = out_q;
  assign pending_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Pulse bits. A retrigger ORs in new bits and reloads the counter, so every
  // bit already active is stretched to the new end time. The bits drop on the
  // edge where the counter steps from 1 to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    if (wr_pulse_i) begin
      pulse_d = pulse_q | wdata_i;
      cnt_d   = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        pulse_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      out_q   <= out_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o   = out_q;
  assign pulse_o = pulse_q;

endmodule : va_ctrl_pio_ch

// File: rtl/va_ctrl_pio.sv
// -----------------------------------------------------------------------------
// va_ctrl_pio
//
// Avalon-MM control PIO for the vector-analyzer generator and sequencer.
// NUM_CH channels of DATA_W bits. Each channel has direct, bit-set and
// bit-clear write access and a timed self-clearing pulse register. Channel
// writes can be double-buffered and committed atomically, either by a CPU
// COMMIT write or by the external sync_commit strobe.
//
// Address map (word addresses):
//   4*i + 0  DATA    rw  write loads shadow, read returns shadow
//   4*i + 1  SET     rw  write ORs into shadow, read returns committed out
//   4*i + 2  CLR     wo  write AND-NOTs shadow, read returns 0
//   4*i + 3  PULSE   rw  write ORs pulse bits and restarts the timer
//   4*N + 0  COMMIT  wo  writedata[NUM_CH-1:0] = channel commit mask
//   4*N + 1  STATUS  ro  pending mask, zero-extended
//   other            reads 0, writes ignored
//
// Build option VA_CTRL_PIO_SHADOW_EN:
//   defined   - double-buffered operation as above.
//   undefined - channel writes act on out_port directly. DATA reads return
//               out. COMMIT and sync_commit have no effect. STATUS reads 0.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   address         word address, ADDR_W = $clog2(NUM_CH)+3
//   chipselect      slave select, qualifies read and write
//   write, read     access strobes
//   writedata       write data
//   readdata        registered read data (readLatency 1), held between reads
//   sync_commit     one-cycle strobe: commit every pending channel
//   out_port        committed values, channel i at [i*DATA_W +: DATA_W]
//   pulse_port      pulse outputs, same packing as out_port
// -----------------------------------------------------------------------------
module va_ctrl_pio
  import va_ctrl_pio_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NUM_CH    = 4,
  parameter  int PULSE_LEN = 4,
  localparam int ADDR_W    = $clog2(NUM_CH) + 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic                     read,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     sync_commit,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic [NUM_CH*DATA_W-1:0] pulse_port
);

  // The upper address bits select a page, the lower two a word in it.
  // PAGE_W always has room for the value NUM_CH (the global page).
  localparam int                PAGE_W      = ADDR_W - 2;
  localparam logic [PAGE_W-1:0] GLOBAL_PAGE = PAGE_W'(NUM_CH);

  logic              wr_en;
  logic              rd_en;
  logic [PAGE_W-1:0] page;
  logic [1:0]        ofs;
  logic              glb_hit;
  logic              commit_wr;

  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_data;
  logic [NUM_CH-1:0] wr_set;
  logic [NUM_CH-1:0] wr_clr;
  logic [NUM_CH-1:0] wr_pulse;
  logic [NUM_CH-1:0] commit_set;
  logic [NUM_CH-1:0] pending;

  logic [DATA_W-1:0] shadow_v [NUM_CH];
  logic [DATA_W-1:0] out_v    [NUM_CH];
  logic [DATA_W-1:0] pulse_v  [NUM_CH];

  logic [DATA_W-1:0] readdata_q, readdata_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign page      = address[ADDR_W-1:2];
  assign ofs       = address[1:0];
  assign glb_hit   = (page == GLOBAL_PAGE);
  assign commit_wr = wr_en & glb_hit & (ofs == OFS_COMMIT);

  // ---------------------------------------------------------------------------
  // Commit set for this cycle: CPU mask OR (sync strobe AND pending).
  // ---------------------------------------------------------------------------
`ifdef VA_CTRL_PIO_SHADOW_EN
  assign commit_set = (commit_wr   ? writedata[NUM_CH-1:0] : '0)
                    | (sync_commit ? pending               : '0);
`else
  logic unused_commit;
  assign unused_commit = commit_wr ^ sync_commit;
  assign commit_set    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_hit[i]   = (page == PAGE_W'(i));
    assign wr_data[i]  = wr_en & ch_hit[i] & (ofs == OFS_DATA);
    assign wr_set[i]   = wr_en & ch_hit[i] & (ofs == OFS_SET);
    assign wr_clr[i]   = wr_en & ch_hit[i] & (ofs == OFS_CLR);
    assign wr_pulse[i] = wr_en & ch_hit[i] & (ofs == OFS_PULSE);

    va_ctrl_pio_ch #(
      .DATA_W    (DATA_W),
      .PULSE_LEN (PULSE_LEN)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_data_i  (wr_data[i]),
      .wr_set_i   (wr_set[i]),
      .wr_clr_i   (wr_clr[i]),
      .wr_pulse_i (wr_pulse[i]),
      .wdata_i    (writedata),
      .commit_i   (commit_set[i]),
      .shadow_o   (shadow_v[i]),
      .out_o      (out_v[i]),
      .pending_o  (pending[i]),
      .pulse_o    (pulse_v[i])
    );

    assign out_port  [i*DATA_W +: DATA_W] = out_v[i];
    assign pulse_port[i*DATA_W +: DATA_W] = pulse_v[i];
  end

  // ---------------------------------------------------------------------------
  // Read mux. It sees register state from before the edge, so a read of a
  // word written in the same cycle returns the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
        case (ofs)
          OFS_DATA:  readdata_d = shadow_v[i];
          OFS_SET:   readdata_d = out_v[i];
          OFS_PULSE: readdata_d = pulse_v[i];
          default:   readdata_d = '0;
        endcase
      end
    end
    // pending is all-zero in the direct build, so STATUS then reads 0.
    if (glb_hit && (ofs == OFS_STATUS)) begin
      readdata_d = DATA_W'(pending);
    end
  end

  // readdata only reloads on an accepted read and holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (rd_en) begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule : va_ctrl_pio

// File: tb/tb_va_ctrl_pio.sv
// -----------------------------------------------------------------------------
// tb_va_ctrl_pio
//
// Self-checking bench for va_ctrl_pio (DATA_W=32, NUM_CH=4, PULSE_LEN=4).
// A behavioural model tracks registers as plain arrays, with pulses held as
// absolute expiry edge numbers. A compare process checks out_port, pulse_port
// and readdata against it on every falling edge. Directed steps also check
// hand-computed literals. Expected values follow VA_CTRL_PIO_SHADOW_EN.
// -----------------------------------------------------------------------------
module tb_va_ctrl_pio;

  localparam int DATA_W    = 32;
  localparam int NUM_CH    = 4;
  localparam int PULSE_LEN = 4;
  localparam int ADDR_W    = 5;
  localparam int VEC_W     = NUM_CH * DATA_W;

  localparam logic [4:0] A_COMMIT = 5'd16;
  localparam logic [4:0] A_STATUS = 5'd17;

`ifdef VA_CTRL_PIO_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic              sync_commit = 1'b0;
  logic [VEC_W-1:0]  out_port;
  logic [VEC_W-1:0]  pulse_port;

  always #5 clk = ~clk;

  va_ctrl_pio #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .PULSE_LEN (PULSE_LEN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .writedata   (writedata),
    .readdata    (readdata),
    .sync_commit (sync_commit),
    .out_port    (out_port),
    .pulse_port  (pulse_port)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] out_ch(input int c);
    return out_port[c*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] pulse_ch(input int c);
    return pulse_port[c*DATA_W +: DATA_W];
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] m_shadow [NUM_CH];
  logic [DATA_W-1:0] m_out    [NUM_CH];
  logic [DATA_W-1:0] m_pulse  [NUM_CH];
  int                m_expire [NUM_CH];
  logic [NUM_CH-1:0] m_pend;
  logic [DATA_W-1:0] m_rdata;
  int                edge_n = 0;
  bit                model_on = 1'b0;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = '0;
      m_out[c]    = '0;
      m_pulse[c]  = '0;
      m_expire[c] = 0;
    end
    m_pend  = '0;
    m_rdata = '0;
  endtask

  function automatic logic [DATA_W-1:0] m_read(input logic [4:0] a);
    int pg = int'(a) / 4;
    int of = int'(a) % 4;
    if (pg < NUM_CH) begin
      if (of == 0) return SHADOW ? m_shadow[pg] : m_out[pg];
      if (of == 1) return m_out[pg];
      if (of == 3) return m_pulse[pg];
      return '0;
    end
    if (pg == NUM_CH && of == 1) return SHADOW ? DATA_W'(m_pend) : '0;
    return '0;
  endfunction

  // Applies one clock edge with the bus inputs that were present before it.
  task automatic model_edge(input logic [4:0] a, input bit wr, input bit rd,
                            input logic [DATA_W-1:0] wd, input bit sync);
    int pg = int'(a) / 4;
    int of = int'(a) % 4;
    logic [NUM_CH-1:0] cset;
    edge_n++;
    if (rd) m_rdata = m_read(a);
    // Pulse expiry, unless this edge retriggers the channel.
    for (int c = 0; c < NUM_CH; c++) begin
      if (!(wr && pg == c && of == 3) && edge_n >= m_expire[c]) m_pulse[c] = '0;
    end
    if (SHADOW) begin
      cset = ((wr && pg == NUM_CH && of == 0) ? wd[NUM_CH-1:0] : '0)
           | (sync ? m_pend : '0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (cset[c]) begin
          m_out[c]  = m_shadow[c];
          m_pend[c] = 1'b0;
        end
      end
    end
    if (wr && pg < NUM_CH) begin
      if (of == 3) begin
        m_pulse[pg]  = m_pulse[pg] | wd;
        m_expire[pg] = edge_n + PULSE_LEN;
      end else if (SHADOW) begin
        m_shadow[pg] = (of == 0) ? wd : (of == 1) ? (m_shadow[pg] | wd)
                                                  : (m_shadow[pg] & ~wd);
        m_pend[pg]   = 1'b1;
      end else begin
        m_out[pg] = (of == 0) ? wd : (of == 1) ? (m_out[pg] | wd)
                                               : (m_out[pg] & ~wd);
      end
    end
  endtask

  // Compare process: every falling edge while the model is live.
  always @(negedge clk) begin : cmp
    logic [VEC_W-1:0] eo;
    logic [VEC_W-1:0] ep;
    if (model_on) begin
      for (int c = 0; c < NUM_CH; c++) begin
        eo[c*DATA_W +: DATA_W] = m_out[c];
        ep[c*DATA_W +: DATA_W] = m_pulse[c];
      end
      check("cmp out_port", out_port, eo);
      check("cmp pulse_port", pulse_port, ep);
      check("cmp readdata", VEC_W'(readdata), VEC_W'(m_rdata));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks: inputs change 1 time unit after a rising edge, last one cycle.
  // ---------------------------------------------------------------------------
  task automatic bus(input logic [4:0] a, input bit cs, input bit wr, input bit rd,
                     input logic [DATA_W-1:0] wd, input bit sync);
    address     = a;
    chipselect  = cs;
    write       = wr;
    read        = rd;
    writedata   = wd;
    sync_commit = sync;
    @(posedge clk);
    model_edge(a, cs && wr, cs && rd, wd, sync);
    #1;
    address     = '0;
    chipselect  = 1'b0;
    write       = 1'b0;
    read        = 1'b0;
    writedata   = '0;
    sync_commit = 1'b0;
  endtask

  task automatic idle();
    bus(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [DATA_W-1:0] d);
    bus(a, 1'b1, 1'b1, 1'b0, d, 1'b0);
  endtask

  // Read, then sample readdata one edge later.
  task automatic rd_reg(input logic [4:0] a, output logic [DATA_W-1:0] v);
    bus(a, 1'b1, 1'b0, 1'b1, '0, 1'b0);
    idle();
    v = readdata;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    logic [DATA_W-1:0] v;
    int c0, c1, l0, l1;

    // Reset and read every mapped word.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    model_on = 1'b1;
    check("reset out_port", out_port, '0);
    check("reset pulse_port", pulse_port, '0);
    check("reset readdata", VEC_W'(readdata), '0);
    for (int a = 0; a < 18; a++) begin
      rd_reg(5'(a), v);
      check($sformatf("reset read addr %0d", a), VEC_W'(v), '0);
    end

    // DATA/SET/CLR on channel 1, then COMMIT.
    wr_reg(5'd4, 32'h0000_00F0);
    wr_reg(5'd5, 32'h0000_0001);
    wr_reg(5'd6, 32'h0000_0010);
    rd_reg(A_STATUS, v);
    check("status after ch1 writes", VEC_W'(v), SHADOW ? 'h2 : 'h0);
    check("ch1 out before commit", VEC_W'(out_ch(1)), SHADOW ? 'h0 : 'hE1);
    rd_reg(5'd4, v);
    check("ch1 DATA read", VEC_W'(v), 'hE1);
    wr_reg(A_COMMIT, 32'h2);
    check("ch1 out after commit", VEC_W'(out_ch(1)), 'hE1);
    rd_reg(A_STATUS, v);
    check("status after commit", VEC_W'(v), 'h0);
    rd_reg(5'd5, v);
    check("ch1 SET read returns out", VEC_W'(v), 'hE1);
    rd_reg(5'd6, v);
    check("ch1 CLR read", VEC_W'(v), 'h0);

    // Two channels committed together by sync_commit.
    wr_reg(5'd0, 32'hA5);
    wr_reg(5'd12, 32'h5A);
    check("ch0 before sync", VEC_W'(out_ch(0)), SHADOW ? 'h0 : 'hA5);
    check("ch3 before sync", VEC_W'(out_ch(3)), SHADOW ? 'h0 : 'h5A);
    bus(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("ch0 after sync", VEC_W'(out_ch(0)), 'hA5);
    check("ch3 after sync", VEC_W'(out_ch(3)), 'h5A);
    rd_reg(A_STATUS, v);
    check("status after sync", VEC_W'(v), 'h0);

    // Write and commit of channel 2 on the same edge.
    wr_reg(5'd8, 32'h3);
    bus(5'd8, 1'b1, 1'b1, 1'b0, 32'h7, 1'b1);
    check("ch2 out takes pre-write shadow", VEC_W'(out_ch(2)), SHADOW ? 'h3 : 'h7);
    rd_reg(A_STATUS, v);
    check("status bit2 stays pending", VEC_W'(v), SHADOW ? 'h4 : 'h0);
    rd_reg(5'd8, v);
    check("ch2 DATA read", VEC_W'(v), 'h7);
    bus(5'd8, 1'b1, 1'b1, 1'b1, 32'h9, 1'b0);
    idle();
    check("ch2 read during write", VEC_W'(readdata), 'h7);
    wr_reg(A_COMMIT, 32'h4);
    check("ch2 out after commit", VEC_W'(out_ch(2)), 'h9);

    // Pulse retrigger on channel 0.
    c0 = 0; c1 = 0; l0 = -1; l1 = -1;
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      wr_reg(5'd3, 32'h1);
      else if (j == 2) wr_reg(5'd3, 32'h2);
      else if (j == 3) bus(5'd3, 1'b1, 1'b0, 1'b1, '0, 1'b0);
      else             idle();
      if (pulse_port[0]) begin c0++; l0 = j; end
      if (pulse_port[1]) begin c1++; l1 = j; end
    end
    check("pulse bit0 length", VEC_W'(c0), 'd6);
    check("pulse bit1 length", VEC_W'(c1), 'd4);
    check("pulse bit0 last cycle", VEC_W'(l0), 'd5);
    check("pulse bit1 last cycle", VEC_W'(l1), 'd5);
    check("PULSE read mid-pulse", VEC_W'(readdata), 'h3);

    // Asynchronous reset during an active pulse.
    wr_reg(5'd7, 32'hFF);
    idle();
    check("ch1 pulse active", VEC_W'(pulse_ch(1)), 'hFF);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("pulse_port cleared by async reset", pulse_port, '0);
    check("out_port cleared by async reset", out_port, '0);
    check("readdata cleared by async reset", VEC_W'(readdata), '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Direct write, STATUS and COMMIT after reset.
    wr_reg(5'd0, 32'h1234);
    check("ch0 out after DATA write", VEC_W'(out_ch(0)), SHADOW ? 'h0 : 'h1234);
    rd_reg(A_STATUS, v);
    check("status after ch0 write", VEC_W'(v), SHADOW ? 'h1 : 'h0);
    wr_reg(A_COMMIT, 32'h1);
    check("ch0 out after COMMIT", VEC_W'(out_ch(0)), 'h1234);

    // Unmapped accesses and a write without chipselect.
    wr_reg(5'd20, 32'hFFFF_FFFF);
    rd_reg(5'd20, v);
    check("unmapped read 20", VEC_W'(v), 'h0);
    rd_reg(5'd18, v);
    check("unmapped read 18", VEC_W'(v), 'h0);
    bus(5'd4, 1'b0, 1'b1, 1'b0, 32'hFFFF, 1'b0);
    idle();
    check("write without chipselect ignored", VEC_W'(out_ch(1)), 'h0);

    repeat (2) idle();
    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_va_ctrl_pio
